// File: rtl/test_status_reporter_if.sv
// Handshake bundle between a design under test and the status reporter:
// the tohost write channel and its completion response.
interface test_status_reporter_if;
    logic        tohost_valid;
    logic        tohost_ready;
    logic [63:0] tohost_data;
    logic        ack_valid;
    logic        ack_ready;

    // Side that issues tohost writes and consumes responses.
    modport master (
        output tohost_valid,
        output tohost_data,
        output ack_ready,
        input  tohost_ready,
        input  ack_valid
    );

    // The reporter: accepts writes and produces responses.
    modport slave (
        input  tohost_valid,
        input  tohost_data,
        input  ack_ready,
        output tohost_ready,
        output ack_valid
    );
endinterface

// File: rtl/test_status_reporter.sv
// Test status reporter: watches tohost writes from a design under test,
// acknowledges each one, and turns the terminal write into a sticky
// pass/fail verdict with an exit code. An optional watchdog fails the test
// when writes stop arriving. A free-running saturating cycle counter is
// exported for reporting.
module test_status_reporter #(
    parameter int unsigned DRAIN_CYCLES    = 16,
    parameter int unsigned WATCHDOG_CYCLES = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    test_status_reporter_if.slave        bus,
    output logic                         io_success,
    output logic                         io_failure,
    output logic [62:0]                  exit_code,
    output logic [63:0]                  cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_DRAIN,
        ST_PASS,
        ST_FAIL
    } state_e;

    localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES);
    localparam logic [31:0] WDOG_LIMIT = 32'(WATCHDOG_CYCLES);
    localparam bit          WDOG_EN    = (WATCHDOG_CYCLES != 0);

    state_e      state_q,     state_d;
    logic [62:0] exit_code_q, exit_code_d;
    logic        terminal_q,  terminal_d;   // accepted write was terminal
    logic [31:0] drain_q,     drain_d;
    logic [31:0] wdog_q,      wdog_d;
    logic [63:0] cycle_q,     cycle_d;

    logic accept;
    logic wdog_expired;

    // Ready depends on state only, so it reads 1 while reset holds IDLE;
    // nothing can be accepted then because the flops are held in reset.
    assign bus.tohost_ready = (state_q == ST_IDLE);
    assign bus.ack_valid    = (state_q == ST_ACK);
    assign accept           = bus.tohost_valid && bus.tohost_ready;
    assign wdog_expired     = WDOG_EN && (wdog_q >= WDOG_LIMIT);

    assign io_success  = (state_q == ST_PASS);
    assign io_failure  = (state_q == ST_FAIL);
    assign exit_code   = exit_code_q;
    assign cycle_count = cycle_q;

    // Saturating cycle counter; keeps running in the terminal states.
    assign cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 64'd1;

    // Next-state, exit-code, drain and watchdog computation.
    always_comb begin
        // NOTE: each next-state variable takes its hold value first, so no path below leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        exit_code_d = exit_code_q;
        terminal_d  = terminal_q;
        drain_d     = drain_q;
        wdog_d      = wdog_q;

        unique case (state_q)
            ST_IDLE: begin
                // An accept beats a watchdog expiry in the same cycle.
                if (accept) begin
                    state_d    = ST_ACK;
                    // Zero and heartbeat writes are both plain non-terminal
                    // writes; only bit 0 selects the terminal path.
                    terminal_d = bus.tohost_data[0];
                    if (bus.tohost_data[0]) begin
                        exit_code_d = bus.tohost_data[63:1];
                    end
                end else if (wdog_expired) begin
                    state_d     = ST_FAIL;
                    exit_code_d = '1;
                end
            end

            ST_ACK: begin
                // A stalled response must not hide a hung design, so the
                // watchdog is honoured here before the response.
                if (wdog_expired) begin
                    state_d     = ST_FAIL;
                    exit_code_d = '1;
                end else if (bus.ack_ready) begin
                    if (terminal_q) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_q == 32'd0) begin
                    state_d = (exit_code_q == '0) ? ST_PASS : ST_FAIL;
                end else begin
                    drain_d = drain_q - 32'd1;
                end
            end

            default: begin
                // PASS and FAIL hold until reset.
                state_d = state_q;
            end
        endcase

        // Watchdog only runs while the design is expected to make progress.
        if (WDOG_EN && ((state_q == ST_IDLE) || (state_q == ST_ACK))) begin
            if (accept) begin
                wdog_d = '0;
            end else if (!wdog_expired) begin
                wdog_d = wdog_q + 32'd1;
            end
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            exit_code_q <= '0;
            terminal_q  <= 1'b0;
            drain_q     <= '0;
            wdog_q      <= '0;
            cycle_q     <= '0;
        end else begin
            // NOTE: non-blocking updates make every flop sample the pre-edge values, independent of statement order.
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
            terminal_q  <= terminal_d;
            drain_q     <= drain_d;
            wdog_q      <= wdog_d;
            cycle_q     <= cycle_d;
        end
    end

endmodule

// File: doc/test_status_reporter.md
TEST_STATUS_REPORTER -- requirements
Module: test_status_reporter

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 16, cycles to hold off the verdict after the terminal write (lets console output flush).
REQ-002 Parameter: WATCHDOG_CYCLES, default 0, max cycles between accepted writes; 0 disables the watchdog.
REQ-003 Port: clock  input  1  single clock; all state on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low; asserted when 0.
REQ-005 Port: tohost_valid  input  1  DUT presents a tohost write.
REQ-006 Port: tohost_ready  output  1  reporter accepts the write.
REQ-007 Port: tohost_data  input  64  written value.
REQ-008 Port: ack_valid  output  1  write-completion response to DUT.
REQ-009 Port: ack_ready  input  1  DUT takes the response.
REQ-010 Port: io_success  output  1  test passed; sticky.
REQ-011 Port: io_failure  output  1  test failed; sticky.
REQ-012 Port: exit_code  output  63  tohost_data[63:1] of the terminal write; all-ones on watchdog expiry.
REQ-013 Port: cycle_count  output  64  cycles since reset release, saturating.

Function
REQ-014 States: IDLE, ACK, DRAIN, PASS, FAIL.
REQ-015 Handshake: write accepted on the cycle tohost_valid && tohost_ready; tohost_ready = 1 only in IDLE.
REQ-016 Accept in IDLE -> ACK next cycle; ack_valid = 1 only in ACK; leave ACK on ack_valid && ack_ready.
REQ-017 Decode on accept: data == 0 -> no-op; data[0] == 0 with data != 0 -> heartbeat; data[0] == 1 -> terminal, exit_code <= data[63:1].
REQ-018 From ACK on response taken: non-terminal -> IDLE; terminal -> DRAIN with drain counter loaded to DRAIN_CYCLES.
REQ-019 DRAIN decrements once per cycle; at count 0 -> PASS if exit_code == 0, else FAIL; DRAIN_CYCLES = 0 -> decision on the first DRAIN cycle.
REQ-020 io_success = 1 in PASS; io_failure = 1 in FAIL; the two are never 1 together.
REQ-021 PASS and FAIL are terminal; tohost_ready = 0 and ack_valid = 0; only reset leaves them.
REQ-022 Watchdog (WATCHDOG_CYCLES > 0): counter clears on every accept; counts in IDLE and ACK only.
REQ-023 Watchdog reaching WATCHDOG_CYCLES -> FAIL next cycle with exit_code = all-ones, including while ACK is stalled.
REQ-024 Watchdog expiry and accept in the same cycle: the accept wins; the counter clears.
REQ-025 cycle_count increments every cycle out of reset, holds at 2^64-1, and keeps counting in PASS and FAIL.
REQ-026 exit_code changes only on a terminal accept or on watchdog expiry.

Reset
REQ-027 Reset asserted: state = IDLE; outputs io_success = 0, io_failure = 0, ack_valid = 0, exit_code = 0, cycle_count = 0; watchdog and drain counters = 0.
REQ-028 tohost_ready is combinational from state, so it reads 1 during reset; no write is accepted and no state changes while reset is asserted.
REQ-029 Reset assertion is asynchronous from any state, including mid-ACK and mid-DRAIN; deassertion is sampled on clock and the first count follows the first edge after release.

Verification
REQ-030 Pass: write 0x1 with ack_ready = 1 -> ack_valid for 1 cycle; io_success = 1 exactly DRAIN_CYCLES + 2 cycles after accept; exit_code = 0.
REQ-031 Fail code: write 0x2B -> io_failure = 1, exit_code = 0x15; io_success stays 0.
REQ-032 Backpressure: ack_ready = 0 for 5 cycles after accept -> ack_valid holds 1, tohost_ready = 0; a second tohost_valid is not accepted until after the response.
REQ-033 Watchdog with WATCHDOG_CYCLES = 10, no writes -> io_failure = 1 on cycle 11, exit_code all-ones; heartbeat 0x2 every 8 cycles -> no failure.
REQ-034 Reset mid-DRAIN -> all outputs return to reset values immediately; a following write 0x1 passes normally.
REQ-035 Terminal lockout: after PASS, drive tohost_valid with 0x3 -> never accepted; io_success, io_failure and exit_code unchanged.
